// File: rtl/fetch_align_buf_pkg.sv
// Shared definitions for the instruction fetch/alignment buffer.
//   HW_W   : halfword width (the queue's storage unit)
//   QDEPTH : number of halfword entries in the alignment queue
//   CNT_W  : width of the queue occupancy counter (0..QDEPTH)
//   is_rvc : true when a halfword is the low half of a compressed instruction
package fetch_align_buf_pkg;

    localparam int HW_W   = 16;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 3;

    typedef logic [HW_W-1:0] halfword_t;

    // RV32C: any encoding whose two low bits are not 2'b11 is 16 bits long.
    function automatic logic is_rvc(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buf_hw_queue.sv
// Four-entry halfword shift queue used to realign fetched words into
// instructions. Entry 0 is the head.
//   clk, reset     : clock, synchronous active-high reset (clears entries)
//   flush          : empties the queue at the edge (ignores push/consume)
//   consume_n      : halfwords removed from the head this cycle (0, 1 or 2)
//   push           : push_word is appended this cycle
//   push_word      : fetched 32-bit word, low half enters the queue first
//   push_skip_low  : drop the low half of push_word, append only the high half
//   head0, head1   : entries 0 and 1 (enough to form one instruction)
//   count          : current occupancy
//   count_next     : occupancy after this cycle's consume and push
module fetch_align_buf_hw_queue
    import fetch_align_buf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       consume_n,
    input  logic             push,
    input  logic [31:0]      push_word,
    input  logic             push_skip_low,
    output halfword_t        head0,
    output halfword_t        head1,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    logic [QDEPTH-1:0][HW_W-1:0] hw_reg;
    logic [QDEPTH-1:0][HW_W-1:0] hw_next;
    logic [QDEPTH-1:0][HW_W-1:0] hw_shifted;
    logic [CNT_W-1:0]            count_reg;
    logic [CNT_W-1:0]            count_after_consume;
    logic [CNT_W-1:0]            push_n;

    // Consumption is a plain right shift of the packed entry vector; the
    // vacated top entries fill with zeros.
    assign hw_shifted          = hw_reg >> (HW_W * consume_n);
    assign count_after_consume = count_reg - {1'b0, consume_n};
    assign push_n              = !push ? CNT_W'(0) : (push_skip_low ? CNT_W'(1) : CNT_W'(2));
    assign count_next          = count_after_consume + push_n;

    // New halfwords land right behind whatever survives this cycle's
    // consumption, so the write slot is relative to count_after_consume.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
            assign hw_next[gi] =
                (push && count_after_consume == IDX)
                    ? (push_skip_low ? push_word[31:16] : push_word[15:0])
                : (push && !push_skip_low && (count_after_consume + CNT_W'(1)) == IDX)
                    ? push_word[31:16]
                    : hw_shifted[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            hw_reg    <= '0;
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            hw_reg    <= hw_next;
            count_reg <= count_next;
        end
    end

    // Fetch throttling guarantees an arriving word always fits.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            assert ({1'b0, count_after_consume} + {1'b0, push_n} <= (CNT_W + 1)'(QDEPTH));
        end
    end

    assign head0 = hw_reg[0];
    assign head1 = hw_reg[1];
    assign count = count_reg;

endmodule

// File: rtl/fetch_align_buf.sv
// Instruction fetch/alignment buffer feeding the RV32IC decoder. Fetches
// aligned words, queues them as halfwords and presents one 16- or 32-bit
// instruction at a time, including 32-bit instructions that straddle words.
//   clk, reset             : clock, synchronous active-high reset
//   imem_req, imem_addr    : word fetch request and word-aligned address
//   imem_rdata, imem_valid : fetched word, returned one cycle after request
//   stall                  : decode cannot take the current instruction
//   jmp, jmp_pc            : one-cycle redirect and its target (bit 0 ignored)
//   instr, instr_pc        : current instruction (compressed zero-extended), PC
//   instr_valid            : instr/instr_pc/instr_is_c are meaningful
//   instr_is_c             : instr is a 16-bit compressed instruction
module fetch_align_buf
    import fetch_align_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_is_c
);

    halfword_t        q_head0;
    halfword_t        q_head1;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_count_next;
    logic [1:0]       consume_n;
    logic             consume;
    logic             push;
    logic             head_is_c;
    logic             head_ready;
    logic [31:0]      jmp_word_addr;
    logic             unused_jmp_lsb;

    logic [31:0]      head_pc_reg;
    logic [31:0]      fetch_addr_reg;
    logic             skip_low_reg;
    logic             post_reset_reg;

    assign unused_jmp_lsb = jmp_pc[0];

    assign head_is_c  = is_rvc(q_head0);
    assign head_ready = head_is_c ? (q_count >= CNT_W'(1)) : (q_count >= CNT_W'(2));

    // A redirect hides the old head in the same cycle so decode never sees
    // an instruction from the abandoned path alongside the jump.
    assign instr_valid = !reset && !jmp && head_ready;
    assign consume     = instr_valid && !stall;
    assign consume_n   = !consume ? 2'd0 : (head_is_c ? 2'd1 : 2'd2);

    // Data returning during reset, the cycle right after it, or a redirect
    // cycle belongs to a request from the abandoned stream.
    assign push = imem_valid && !jmp && !reset && !post_reset_reg;

    assign jmp_word_addr = {jmp_pc[31:2], 2'b00};
    assign imem_req      = !reset && (jmp || q_count_next <= CNT_W'(2));
    assign imem_addr     = jmp ? jmp_word_addr : fetch_addr_reg;

    assign instr      = reset ? 32'h0 : (head_is_c ? {16'h0, q_head0} : {q_head1, q_head0});
    assign instr_pc   = reset ? RESET_PC : head_pc_reg;
    assign instr_is_c = !reset && head_is_c;

    fetch_align_buf_hw_queue u_queue (
        .clk           (clk),
        .reset         (reset),
        .flush         (jmp),
        .consume_n     (consume_n),
        .push          (push),
        .push_word     (imem_rdata),
        .push_skip_low (skip_low_reg),
        .head0         (q_head0),
        .head1         (q_head1),
        .count         (q_count),
        .count_next    (q_count_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc_reg    <= RESET_PC;
            fetch_addr_reg <= {RESET_PC[31:2], 2'b00};
            skip_low_reg   <= 1'b0;
            post_reset_reg <= 1'b1;
        end else begin
            post_reset_reg <= 1'b0;
            if (jmp) begin
                head_pc_reg    <= {jmp_pc[31:1], 1'b0};
                // A target at bit1=1 begins in the high half of its word.
                skip_low_reg   <= jmp_pc[1];
                fetch_addr_reg <= jmp_word_addr + 32'd4;
            end else begin
                if (consume) begin
                    head_pc_reg <= head_pc_reg + (head_is_c ? 32'd2 : 32'd4);
                end
                if (push) begin
                    skip_low_reg <= 1'b0;
                end
                if (imem_req) begin
                    fetch_addr_reg <= fetch_addr_reg + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_buf.sv
module tb_fetch_align_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_is_c;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    int          idle = 0;

    always #5 clk = ~clk;

    fetch_align_buf #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .jmp         (jmp),
        .jmp_pc      (jmp_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_is_c  (instr_is_c)
    );

    // Instruction memory: answers every request one cycle later.
    always @(posedge clk) begin
        imem_valid <= imem_req;
        imem_rdata <= mem[imem_addr[9:2]];
    end

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the instruction stream is a walk over memory starting at
    // exp_pc; each accepted instruction must be the next step of that walk.
    task automatic accept();
        logic [15:0] h0;
        logic        c;
        logic [31:0] e;
        h0 = hw_at(exp_pc);
        c  = (h0[1:0] != 2'b11);
        e  = c ? {16'h0, h0} : {hw_at(exp_pc + 32'd2), h0};
        check("model_pc", instr_pc, exp_pc);
        check("model_instr", instr, e);
        check("model_is_c", 32'(instr_is_c), 32'(c));
        $display("xact pc=%h instr=%h c=%0d", instr_pc, instr, instr_is_c);
        exp_pc = exp_pc + (c ? 32'd2 : 32'd4);
    endtask

    // One clock cycle: drive inputs after the falling edge, let the
    // combinational outputs settle, then compare against the model.
    task automatic step(input logic r, input logic st, input logic j, input logic [31:0] jp);
        @(negedge clk);
        reset = r; stall = st; jmp = j; jmp_pc = jp;
        #1;
        if (r) begin
            exp_pc = 32'h0;
            idle = 0;
        end else if (j) begin
            check("jmp_cycle_valid", 32'(instr_valid), 32'd0);
            exp_pc = {jp[31:1], 1'b0};
            idle = 0;
        end else begin
            if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            if (instr_valid) begin
                idle = 0;
                if (!st) accept();
            end else begin
                idle++;
                if (idle == 5) check("valid_within_bound", 32'(instr_valid), 32'd1);
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // ---- straight-line 32-bit program ----
        mem[0] = 32'h00500093; mem[1] = 32'h00100113;
        mem[2] = 32'h002081B3; mem[3] = 32'h00000013;
        do_reset(3);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_is_c", 32'(instr_is_c), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("c1_valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check("seq_valid", 32'(instr_valid), 32'd1);
            check("seq_pc", instr_pc, 32'(4 * k));
            check("seq_is_c", 32'(instr_is_c), 32'd0);
        end
        check("seq_first_instr_at_pc_c", instr, 32'h00000013);

        // ---- mixed compressed / 32-bit (reset during active fetching) ----
        mem[0] = 32'h00934501; mem[1] = 32'h45050050;
        mem[2] = 32'h0; mem[3] = 32'h0;
        do_reset(2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mix0_pc", instr_pc, 32'h0);
        check("mix0_instr", instr, 32'h00004501);
        check("mix0_c", 32'(instr_is_c), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mix1_pc", instr_pc, 32'h2);
        check("mix1_instr", instr, 32'h00500093);
        check("mix1_c", 32'(instr_is_c), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mix2_pc", instr_pc, 32'h6);
        check("mix2_instr", instr, 32'h00004505);
        check("mix2_c", 32'(instr_is_c), 32'd1);

        // ---- reset pulse while the queue holds three halfwords ----
        do_reset(1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_valid0", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("restart_valid1", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("restart_valid2", 32'(instr_valid), 32'd1);
        check("restart_pc", instr_pc, 32'h0);
        check("restart_instr", instr, 32'h00004501);

        // ---- stall for five cycles on the first instruction ----
        mem[0] = 32'h00500093; mem[1] = 32'h00100113;
        mem[2] = 32'h002081B3; mem[3] = 32'h00000013;
        do_reset(2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", instr_pc, 32'h0);
            check("stall_instr", instr, 32'h00500093);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check("unstall_valid", 32'(instr_valid), 32'd1);
            check("unstall_pc", instr_pc, 32'(4 * k));
        end

        // ---- redirect into a straddling 32-bit instruction ----
        mem[8'h40] = 32'h00130001; mem[8'h41] = 32'h12345678;
        step(1'b0, 1'b0, 1'b1, 32'h102);
        check("jmp_req", 32'(imem_req), 32'd1);
        check("jmp_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("jmp1_valid", 32'(instr_valid), 32'd0);
        check("jmp1_addr", imem_addr, 32'h104);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("jmp2_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("jmp3_valid", 32'(instr_valid), 32'd1);
        check("jmp3_pc", instr_pc, 32'h102);
        check("jmp3_instr", instr, 32'h56780013);

        // ---- redirect with stall held: old head abandoned ----
        mem[8'h80] = 32'h00000013; mem[8'h81] = 32'h00000013;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        check("jst_addr", imem_addr, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("jst1_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("jst2_valid", 32'(instr_valid), 32'd1);
        check("jst2_pc", instr_pc, 32'h200);
        check("jst2_instr", instr, 32'h00000013);

        // ---- randomized stream with stalls and redirects ----
        do_reset(1);
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset(2);
        for (int k = 0; k < 500; k++) begin
            logic        st;
            logic        j;
            logic [31:0] jp;
            st = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 19) == 0);
            jp = 32'($urandom_range(0, 1023));
            step(1'b0, st, j, jp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
